// File: rtl/gray_counter_pkg.sv
// Shared definitions for the Gray counter controller.
//  - mode_t   : mode FSM state encodings (MANUAL / AUTO)
//  - DIR_UP   : encoding of the "count up" direction
//  - BTN_*    : indices of the three buttons in the conditioner array
//  - clog2    : counter width helper used for the prescaler and debounce counters
package gray_counter_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    localparam logic DIR_UP = 1'b1;

    localparam int NUM_BTN  = 3;
    localparam int BTN_STEP = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_DIR  = 2;

    // Smallest width able to hold values 0..v-1; at least 1 bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gray_counter_ctrl_btn_conditioner.sv
// btn_conditioner: conditions one raw asynchronous push button.
//  - 2-FF synchroniser
//  - stability counter: the clean level follows the synchronised level only
//    after it has differed from the clean level for DEB_CYCLES consecutive cycles
//  - o_press: one-cycle pulse on the clean rising edge (release gives no pulse)
// Raw edge to o_press latency is 2 + DEB_CYCLES + 1 cycles.
// Ports:
//  clk        in  system clock
//  rst        in  synchronous active-high reset
//  i_btn_raw  in  raw button level from the pin
//  o_press    out registered press pulse
module btn_conditioner
    import gray_counter_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int CW = clog2(DEB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_clean;
    logic          r_clean_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;

            // Any cycle where the synced level agrees with the clean level
            // restarts the stability window.
            if (r_sync2 == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_clean <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            r_clean_d <= r_clean;
            r_press   <= r_clean & ~r_clean_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl: board-level N-bit Gray counter driven by three buttons.
//  Manual single-step or free-running AUTO mode (one advance every
//  CLK_HZ/TICK_HZ cycles), up/down direction, wrap-around pulse.
// Optional feature macro: GRAY_STEP_CHECK_EN adds err_sticky, a sticky flag
//  set when any leds update changes a number of bits other than one.
// Ports:
//  clk        in   system clock
//  rst        in   synchronous active-high reset
//  btn_step   in   raw button: advance one step (MANUAL only)
//  btn_mode   in   raw button: toggle MANUAL/AUTO
//  btn_dir    in   raw button: toggle direction
//  leds       out  registered Gray code of the binary count
//  mode_led   out  1 = AUTO, 0 = MANUAL
//  dir_led    out  1 = up, 0 = down
//  wrap       out  one-cycle pulse coincident with a wrapping leds update
//  err_sticky out  (GRAY_STEP_CHECK_EN only) Gray step violation, sticky
module gray_counter_ctrl
    import gray_counter_pkg::*;
#(
    parameter int N          = 8,
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_step,
    input  logic         btn_mode,
    input  logic         btn_dir,
    output logic [N-1:0] leds,
    output logic         mode_led,
    output logic         dir_led,
    output logic         wrap
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic         err_sticky
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = clog2(DIV);

    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] w_press;

    assign w_btn_raw[BTN_STEP] = btn_step;
    assign w_btn_raw[BTN_MODE] = btn_mode;
    assign w_btn_raw[BTN_DIR]  = btn_dir;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_conditioner #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_cond (
                .clk      (clk),
                .rst      (rst),
                .i_btn_raw(w_btn_raw[gi]),
                .o_press  (w_press[gi])
            );
        end
    endgenerate

    mode_t         r_mode;
    logic [PW-1:0] r_presc;
    logic [N-1:0]  r_bin;
    logic [N-1:0]  r_leds;
    logic          r_dir;
    logic          r_wrap;

    logic          w_presc_last;
    logic          w_tick;
    logic [N-1:0]  w_next_bin;
    logic [N-1:0]  w_next_gray;
    logic          w_wrap_now;

    assign w_presc_last = (r_presc == PW'(DIV - 1));
    // In AUTO the step button is ignored; the prescaler alone advances.
    assign w_tick       = (r_mode == AUTO) ? w_presc_last : w_press[BTN_STEP];
    assign w_next_bin   = (r_dir == DIR_UP) ? (r_bin + N'(1)) : (r_bin - N'(1));
    assign w_next_gray  = w_next_bin ^ (w_next_bin >> 1);
    assign w_wrap_now   = (r_dir == DIR_UP) ? (r_bin == '1) : (r_bin == '0);

    // All decisions use the current mode and dir, so a simultaneous mode or
    // dir press only takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MANUAL;
            r_presc <= '0;
            r_bin   <= '0;
            r_leds  <= '0;
            r_dir   <= DIR_UP;
            r_wrap  <= 1'b0;
        end else begin
            case (r_mode)
                MANUAL: begin
                    // Held at 0 so that entering AUTO starts a full period.
                    r_presc <= '0;
                    if (w_press[BTN_MODE]) begin
                        r_mode <= AUTO;
                    end
                end
                AUTO: begin
                    r_presc <= w_presc_last ? '0 : (r_presc + PW'(1));
                    if (w_press[BTN_MODE]) begin
                        r_mode <= MANUAL;
                    end
                end
                default: r_mode <= MANUAL;
            endcase

            if (w_press[BTN_DIR]) begin
                r_dir <= ~r_dir;
            end

            r_wrap <= 1'b0;
            if (w_tick) begin
                r_bin  <= w_next_bin;
                r_leds <= w_next_gray;
                r_wrap <= w_wrap_now;
            end
        end
    end

    assign leds     = r_leds;
    assign mode_led = (r_mode == AUTO);
    assign dir_led  = r_dir;
    assign wrap     = r_wrap;

`ifdef GRAY_STEP_CHECK_EN
    logic         r_err;
    logic [N-1:0] w_diff;
    logic         w_step_bad;

    // A legal Gray step flips exactly one bit: diff is non-zero and a power of two.
    assign w_diff     = w_next_gray ^ r_leds;
    assign w_step_bad = (w_diff == '0) || ((w_diff & (w_diff - N'(1))) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_tick && w_step_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_gray_counter_ctrl.sv
module tb_gray_counter_ctrl;

    localparam int N       = 8;
    localparam int CLK_HZ  = 16;
    localparam int TICK_HZ = 1;
    localparam int DEB     = 4;

    logic         clk;
    logic         rst;
    logic         btn_step;
    logic         btn_mode;
    logic         btn_dir;
    logic [N-1:0] leds;
    logic         mode_led;
    logic         dir_led;
    logic         wrap;
`ifdef GRAY_STEP_CHECK_EN
    logic         err_sticky;
`endif

    int n_total = 0;
    int n_bad   = 0;

    gray_counter_ctrl #(
        .N         (N),
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_mode  (btn_mode),
        .btn_dir   (btn_dir),
        .leds      (leds),
        .mode_led  (mode_led),
        .dir_led   (dir_led),
        .wrap      (wrap)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        btn_dir  = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        btn_dir  = 1'b0;
        cyc(2);
        n_total++; if (leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds: got %h want 00", leds); end
        n_total++; if (mode_led !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b want 0", mode_led); end
        n_total++; if (dir_led !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %b want 1", dir_led); end
        n_total++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
`ifdef GRAY_STEP_CHECK_EN
        n_total++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_sticky); end
`endif
        rst = 1'b0;
        cyc(1);
        $display("reset: leds=%h mode=%b dir=%b wrap=%b", leds, mode_led, dir_led, wrap);
    endtask

    task automatic test_manual_step();
        logic [7:0] exp_seq [3];
        logic [7:0] prev;
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h02;
        prev = 8'h00;
        for (int k = 0; k < 3; k++) begin
            btn_step = 1'b1;
            cyc(7);
            n_total++; if (leds !== prev) begin n_bad++; $display("FAIL step%0d_early: got %h want %h", k, leds, prev); end
            cyc(1);
            n_total++; if (leds !== exp_seq[k]) begin n_bad++; $display("FAIL step%0d_value: got %h want %h", k, leds, exp_seq[k]); end
            $display("step %0d: leds=%h", k, leds);
            cyc(2);
            btn_step = 1'b0;
            cyc(10);
            prev = exp_seq[k];
        end
    endtask

    task automatic test_bounce();
        int hi_len [3];
        hi_len[0] = 3; hi_len[1] = 2; hi_len[2] = 1;
        for (int k = 0; k < 3; k++) begin
            btn_step = 1'b1;
            cyc(hi_len[k]);
            btn_step = 1'b0;
            cyc(2);
        end
        cyc(10);
        n_total++; if (leds !== 8'h02) begin n_bad++; $display("FAIL bounce_ignored: got %h want 02", leds); end
        $display("bounce: leds=%h", leds);
        btn_step = 1'b1;
        cyc(7);
        n_total++; if (leds !== 8'h02) begin n_bad++; $display("FAIL hold_early: got %h want 02", leds); end
        cyc(1);
        n_total++; if (leds !== 8'h06) begin n_bad++; $display("FAIL hold_advance: got %h want 06", leds); end
        cyc(2);
        btn_step = 1'b0;
        cyc(15);
        n_total++; if (leds !== 8'h06) begin n_bad++; $display("FAIL release_no_advance: got %h want 06", leds); end
        $display("hold+release: leds=%h", leds);
    endtask

    task automatic test_down_wrap();
        do_reset();
        cyc(1);
        btn_dir = 1'b1;
        cyc(7);
        n_total++; if (dir_led !== 1'b1) begin n_bad++; $display("FAIL dir_early: got %b want 1", dir_led); end
        cyc(1);
        n_total++; if (dir_led !== 1'b0) begin n_bad++; $display("FAIL dir_toggle: got %b want 0", dir_led); end
        cyc(2);
        btn_dir = 1'b0;
        cyc(10);
        btn_step = 1'b1;
        cyc(7);
        n_total++; if (wrap !== 1'b0 || leds !== 8'h00) begin n_bad++; $display("FAIL down_early: got leds=%h wrap=%b want leds=00 wrap=0", leds, wrap); end
        cyc(1);
        n_total++; if (leds !== 8'h80) begin n_bad++; $display("FAIL down_leds: got %h want 80", leds); end
        n_total++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL down_wrap_on: got %b want 1", wrap); end
        cyc(1);
        n_total++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL down_wrap_off: got %b want 0", wrap); end
        $display("down wrap: dir=%b leds=%h", dir_led, leds);
        cyc(1);
        btn_step = 1'b0;
        cyc(10);
    endtask

    task automatic test_auto();
        int          wraps;
        int          bad_here;
        int          t;
        logic [7:0]  b;
        logic [7:0]  g;
        logic        w_exp;
        logic        m_exp;
        do_reset();
        cyc(1);
        wraps = 0;
        bad_here = 0;
        btn_mode = 1'b1;
        for (int c = 1; c <= 4115; c++) begin
            cyc(1);
            t = (c < 24) ? 0 : ((c - 24) / 16 + 1);
            b = 8'(t);
            g = b ^ (b >> 1);
            w_exp = (c >= 24) && (((c - 24) % 16) == 0) && (t == 256);
            m_exp = (c >= 8);
            if (wrap === 1'b1) wraps++;
            n_total++;
            if (leds !== g || wrap !== w_exp || mode_led !== m_exp) begin
                n_bad++;
                bad_here++;
                if (bad_here < 10)
                    $display("FAIL auto_c%0d: got leds=%h wrap=%b mode=%b want leds=%h wrap=%b mode=%b",
                             c, leds, wrap, mode_led, g, w_exp, m_exp);
            end
            btn_mode = (c < 10);
            btn_step = (c >= 100 && c < 112) || (c >= 300 && c < 312);
        end
        n_total++; if (wraps != 1) begin n_bad++; $display("FAIL auto_wrap_count: got %0d want 1", wraps); end
        n_total++; if (leds !== 8'h00) begin n_bad++; $display("FAIL auto_final: got %h want 00", leds); end
        $display("auto: 256 ticks, leds=%h wraps=%0d", leds, wraps);
    endtask

    task automatic test_reset_mid();
        int spurious;
        cyc(30);
        btn_dir  = 1'b1;
        btn_step = 1'b1;
        btn_mode = 1'b1;
        cyc(4);
        rst = 1'b1;
        btn_dir  = 1'b0;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        cyc(1);
        n_total++;
        if (leds !== 8'h00 || mode_led !== 1'b0 || dir_led !== 1'b1 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_values: got leds=%h mode=%b dir=%b wrap=%b want 00 0 1 0", leds, mode_led, dir_led, wrap);
        end
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (leds !== 8'h00 || mode_led !== 1'b0 || dir_led !== 1'b1 || wrap !== 1'b0) spurious++;
        end
        n_total++; if (spurious != 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d changed cycles want 0", spurious); end
        $display("mid reset: leds=%h mode=%b dir=%b", leds, mode_led, dir_led);
    endtask

    initial begin
        rst = 1'b1;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        btn_dir  = 1'b0;
        test_reset();
        test_manual_step();
        test_bounce();
        test_down_wrap();
        test_auto();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
